// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: latches a mult/div operation and times its latency.
// It owns the HI/LO registers and raises the busy and D-stage stall signals.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        use_md_D,
   input  logic        rd_sel,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;
   localparam logic [3:0] MULT_N  = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N   = 4'(DIV_CYCLES);

   state_t      state;
   logic [3:0]  count;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;

   logic        is_muldiv;
   logic [63:0] mult_s, mult_u;
   logic [31:0] res_hi, res_lo;

   // Opcodes 000-011 have md_op[2] clear; that bit marks the mult/div group.
   assign is_muldiv = ~md_op[2];
   assign md_stall  = use_md_D & (busy | (start & is_muldiv));
   assign rd_data   = rd_sel ? hi : lo;

   assign mult_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign mult_u = {32'b0, a_q} * {32'b0, b_q};

   // The result is always built from the latched operands.
   // A zero divisor leaves HI/LO at their current values.
   // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
   always_comb begin
      res_hi = hi;
      res_lo = lo;
      unique case (op_q)
         2'b00: {res_hi, res_lo} = mult_s;
         2'b01: {res_hi, res_lo} = mult_u;
         2'b10: if (b_q != 32'd0) begin
            res_lo = $signed(a_q) / $signed(b_q);
            res_hi = $signed(a_q) % $signed(b_q);
         end
         2'b11: if (b_q != 32'd0) begin
            res_lo = a_q / b_q;
            res_hi = a_q % b_q;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= 4'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         op_q  <= 2'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (is_muldiv) begin
                     op_q  <= md_op[1:0];
                     a_q   <= src_a;
                     b_q   <= src_b;
                     count <= md_op[1] ? DIV_N : MULT_N;
                     busy  <= 1'b1;
                     state <= RUN;
                  end else if (md_op == OP_MTHI) begin
                     hi <= src_a;
                  end else if (md_op == OP_MTLO) begin
                     lo <= src_a;
                  end
               end
            end
            RUN: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Sequencer for the multiply/divide resource of the five-stage MIPS pipeline. It captures an operation issued from the E stage, holds the HI/LO architectural registers, counts out the multi-cycle latency, and drives `busy` plus a D-stage stall request to the hazard unit so that HI/LO consumers wait for a committed result. It sits beside the ALU in E; its HI/LO read port feeds the E→M result path for `mfhi`/`mflo`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu` (legal range 1–15).
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu` (legal range 1–15).

Ports:
- `clk` input 1: single clock, all state on the rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `start` input 1: E-stage HI/LO-writing instruction valid this cycle.
- `md_op` input 3: operation code. 000 `mult`, 001 `multu`, 010 `div`, 011 `divu`, 100 `mthi`, 101 `mtlo`; 110/111 reserved.
- `src_a` input 32: forwarded rs operand.
- `src_b` input 32: forwarded rt operand.
- `use_md_D` input 1: the D-stage instruction reads or writes HI/LO.
- `rd_sel` input 1: read select, 0 = LO, 1 = HI.
- `busy` output 1: a mult/div operation is in flight.
- `md_stall` output 1: stall request to the hazard unit.
- `rd_data` output 32: the selected HI/LO value (combinational).
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `done` output 1: one-cycle pulse on the cycle after HI/LO commit a mult/div result.

## Operation
- FSM states: IDLE and RUN.
  - IDLE with `start` and `md_op`=000–011: latch operands and op, load the counter with the op's cycle count, go to RUN.
  - RUN: decrement the counter each cycle. On the edge where the counter goes 1→0, write HI/LO, assert `done` for the following cycle, and go to IDLE.
- Starting a mult/div computes the result from the latched operands only; later changes on `src_a`/`src_b` are ignored.
- `mult`: {HI,LO} = signed(src_a) × signed(src_b), 64-bit result.
- `multu`: {HI,LO} = unsigned product.
- `div`: LO = quotient, HI = remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.
- `divu`: unsigned quotient and remainder.
- Divide by zero (src_b = 0): busy runs the full `DIV_CYCLES`, HI/LO are left unchanged, and `done` still pulses.
- `mthi` / `mtlo` in IDLE: write `src_a` to HI or LO on the same edge; `busy` is not asserted and `done` does not pulse.
- `start` while in RUN is ignored. The hazard unit prevents this; the bench checks that it is ignored.
- Reserved `md_op` values are ignored.
- `md_stall` = `use_md_D` & (`busy` | (`start` & md_op is mult/div)).
- `rd_data` = `rd_sel` ? `hi` : `lo`. During RUN it returns the old value; consumers are kept out by `md_stall`.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0. `md_stall` and `rd_data` follow combinationally.
- `start` is sampled at edge t.
- `busy` is high for cycles t+1 through t+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update at the edge ending cycle t+N. `busy` is low and `done` is high in cycle t+N+1.
- Back-to-back: a new `start` is accepted in cycle t+N+1, giving one operation per N+1 cycles at maximum rate.
- `mthi`/`mtlo` are visible on `hi`/`lo` in cycle t+1.
- `reset` asserted mid-RUN aborts the operation. No commit occurs, `done` stays low, and all outputs take their reset values asynchronously.
- `reset` deasserted: the first `start` can be sampled on the next rising edge.

## Test plan
- Reset, then `mult` with src_a=0xFFFFFFFF and src_b=2 → `busy` high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, and `done` pulses once.
- `multu` with 0xFFFFFFFF×2, then `divu` with 7/2 issued in the cycle `done` is high → first result hi=1, lo=0xFFFFFFFE; second `start` accepted, `busy` high for 10 cycles, then lo=3, hi=1.
- `div` with src_a=−7 (0xFFFFFFF9) and src_b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then `div` by 0 → HI/LO unchanged after 10 busy cycles and `done` pulses.
- `mtlo` with src_a=0x1234 in IDLE → lo=0x1234 next cycle, `busy` stays 0, `done` stays 0. Then `rd_sel`=0 → rd_data=0x1234.
- Stall: `use_md_D`=1 together with a `mult` `start` → `md_stall`=1 in the start cycle and in all 5 busy cycles, and 0 in the cycle after. A second `start` pulsed mid-RUN → ignored, with no change to the counter or the result.
- `reset` pulsed low in the 3rd busy cycle of `div` → busy=0, hi=lo=0 immediately, and no `done` pulse.
